// File: rtl/tv_timing_gen.sv
// Composite-video timing generator built on a half-line engine. It produces sync, blank and
// burst, the field/line indices and the PAL V-switch for the CVBS encoder and the OSD overlay.
module tv_timing_gen #(
   parameter int HALF_CLKS   = 768,
   parameter int HSYNC_CLKS  = 114,
   parameter int EQ_CLKS     = 56,
   parameter int BROAD_CLKS  = 655,
   parameter int BLANK_END   = 249,
   parameter int BLANK_START = 1496,
   parameter int BURST_START = 139,
   parameter int BURST_END   = 212,
   parameter int VS_HL       = 5,
   parameter int EQ_HL       = 5
) (
   input  logic        clk24,
   input  logic        reset_n,
   input  logic        ce,
   input  logic        interlace,
   input  logic        field_alt_en,
   input  logic        resync_n,
   output logic        sync_n,
   output logic        blank,
   output logic        burst,
   output logic        vzone,
   output logic        field,
   output logic        pal_alt,
   output logic [10:0] hpos,
   output logic [9:0]  line_num,
   output logic        field_start
);

   localparam logic [10:0] HALF_W     = 11'(HALF_CLKS);
   localparam logic [10:0] HSYNC_W    = 11'(HSYNC_CLKS);
   localparam logic [10:0] EQ_W       = 11'(EQ_CLKS);
   localparam logic [10:0] BROAD_W    = 11'(BROAD_CLKS);
   localparam logic [10:0] BL_END_W   = 11'(BLANK_END);
   localparam logic [10:0] BL_START_W = 11'(BLANK_START);
   localparam logic [10:0] BU_START_W = 11'(BURST_START);
   localparam logic [10:0] BU_END_W   = 11'(BURST_END);
   localparam logic [9:0]  VS_W       = 10'(VS_HL);
   localparam logic [9:0]  EQ_HL_W    = 10'(EQ_HL);

   logic [10:0] pos;
   logic [9:0]  hl;
   logic        fld;
   logic        frame;
   logic        resync_q;

   logic        resync_fall;
   logic        pos_wrap;
   logic        hl_wrap;
   logic        par;
   logic [9:0]  hl_last;
   logic [10:0] hpos_c;
   logic [10:0] line_sum;
   logic        broad_c;
   logic        equal_c;
   logic        vzone_c;
   logic        sync_c;

   always_comb begin
      resync_fall = resync_q & ~resync_n;
      hl_last     = interlace ? 10'd624 : 10'd623;
      pos_wrap    = (pos >= HALF_W - 11'd1);
      hl_wrap     = (hl >= hl_last);
      // A line starts on an even-parity half-line. Field 1 is offset by half a line.
      par         = hl[0] ^ fld;
      hpos_c      = par ? pos + HALF_W : pos;
      // The line index counts line starts seen since hl 0. In field 1 the first one falls on hl 1.
      line_sum    = {1'b0, hl} + {10'd0, fld};
      broad_c     = (hl < VS_W);
      equal_c     = ((hl >= VS_W) && (hl < VS_W + EQ_HL_W)) || (hl > hl_last - EQ_HL_W);
      vzone_c     = broad_c | equal_c;
      if (broad_c)
         sync_c = (pos < BROAD_W);
      else if (equal_c)
         sync_c = (pos < EQ_W);
      else
         sync_c = (hpos_c < HSYNC_W);
   end

   // Half-line engine. An external vsync edge overrides ce and any natural wrap.
   always_ff @(posedge clk24 or negedge reset_n) begin
      if (!reset_n) begin
         pos      <= '0;
         hl       <= '0;
         fld      <= 1'b0;
         frame    <= 1'b0;
         resync_q <= 1'b1;
      end else begin
         resync_q <= resync_n;
         if (resync_fall) begin
            pos <= '0;
            hl  <= '0;
            fld <= 1'b0;
         end else if (ce) begin
            if (pos_wrap) begin
               pos <= '0;
               if (hl_wrap) begin
                  hl  <= '0;
                  fld <= interlace & ~fld;
                  if (!interlace || fld)
                     frame <= ~frame;
               end else begin
                  hl <= hl + 10'd1;
               end
            end else begin
               pos <= pos + 11'd1;
            end
         end
      end
   end

   always_ff @(posedge clk24 or negedge reset_n) begin
      if (!reset_n) begin
         sync_n      <= 1'b1;
         blank       <= 1'b1;
         burst       <= 1'b0;
         vzone       <= 1'b1;
         field       <= 1'b0;
         pal_alt     <= 1'b0;
         hpos        <= '0;
         line_num    <= '0;
         field_start <= 1'b0;
      end else begin
         sync_n      <= ~sync_c;
         blank       <= vzone_c | (hpos_c < BL_END_W) | (hpos_c >= BL_START_W);
         burst       <= ~vzone_c & (hpos_c >= BU_START_W) & (hpos_c < BU_END_W);
         vzone       <= vzone_c;
         field       <= fld;
         pal_alt     <= line_sum[1] ^ (field_alt_en & frame);
         hpos        <= hpos_c;
         line_num    <= line_sum[10:1];
         field_start <= ce & (hl == 10'd0) & (pos == 11'd0);
      end
   end

endmodule
